key_conditioner: RTL

- Upstream stage of the Genius game top. Turns the four raw, active-low, bouncing board keys into clean signals for the datapath and control FSM.
- Synchronises each key and debounces it with a per-key state machine.
- Emits a one-cycle press pulse per key, plus an encoded "colour pressed" event with lockout when more than one key is held.
- Outputs feed KEY_i of the datapath in place of the raw KEY bus.

---
 rtl/genius_pkg.sv | 25 ++
 rtl/key_debounce.sv | 96 +++++++++
 rtl/key_conditioner.sv | 65 ++++++
 3 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game blocks: key FSM encoding, code width,
// default debounce timing and a small bit-count helper.
package genius_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int KEY_CODE_W = 2;

    // 20 ms of stable level at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_CNT_W           = 20;

    function automatic int unsigned count_ones(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One board key: two-flop synchroniser, stable-level counter and debounce FSM.
// Produces the debounced level, a one-cycle press pulse and a next-level lookahead.
module key_debounce
    import genius_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset_i,
    input  logic key_n_i,
    output logic held_o,
    output logic press_o,
    output logic held_nxt_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1, sync_q2;
    logic             s;
    logic             done;
    key_state_e       state;
    logic [CNT_W-1:0] count;

    // Reset to the released level so a key held through reset still needs
    // the full acceptance time afterwards.
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_n_i;
            sync_q2 <= sync_q1;
        end
    end

    assign s    = ~sync_q2;
    assign done = (count == LAST);

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            count   <= '0;
            held_o  <= 1'b0;
            press_o <= 1'b0;
        end else begin
            press_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        count <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (done) begin
                        state   <= PRESSED;
                        held_o  <= 1'b1;
                        press_o <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        count <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state <= PRESSED;
                    end else if (done) begin
                        state  <= IDLE;
                        held_o <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            endcase
        end
    end

    // Value held_o takes at the next edge; lets the top register multi_o
    // in the same cycle held_o changes.
    always_comb begin
        held_nxt_o = held_o;
        if (state == PRESS_WAIT && s && done)
            held_nxt_o = 1'b1;
        else if (state == RELEASE_WAIT && !s && done)
            held_nxt_o = 1'b0;
    end

endmodule

// File: rtl/key_conditioner.sv
// Board key front end: per-key debounce, enable gating of press pulses,
// single-key colour encoder with lockout, and multi-key indication.
module key_conditioner
    import genius_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset_i,
    input  logic [N_KEYS-1:0]     key_n_i,
    input  logic                  enable_i,
    output logic [N_KEYS-1:0]     held_o,
    output logic [N_KEYS-1:0]     press_o,
    output logic [KEY_CODE_W-1:0] code_o,
    output logic                  valid_o,
    output logic                  multi_o
);

    logic [N_KEYS-1:0]     press_raw;
    logic [N_KEYS-1:0]     held_nxt;
    logic [KEY_CODE_W-1:0] press_idx;
    logic                  single_press;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_key (
            .clock      (clock),
            .reset_i    (reset_i),
            .key_n_i    (key_n_i[k]),
            .held_o     (held_o[k]),
            .press_o    (press_raw[k]),
            .held_nxt_o (held_nxt[k])
        );
    end

    // Debounce keeps running while disabled; a press accepted then is dropped.
    assign press_o = press_raw & {N_KEYS{enable_i}};

    always_comb begin
        press_idx = '0;
        for (int k = 0; k < N_KEYS; k++)
            if (press_o[k]) press_idx = KEY_CODE_W'(k);
    end

    // The pressing key is itself held this cycle, so only other held keys lock out.
    assign single_press = (count_ones(32'(press_o)) == 32'd1) &&
                          ((held_o & ~press_o) == '0);

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            code_o  <= '0;
            valid_o <= 1'b0;
            multi_o <= 1'b0;
        end else begin
            valid_o <= single_press;
            if (single_press) code_o <= press_idx;
            multi_o <= (count_ones(32'(held_nxt)) >= 32'd2);
        end
    end

endmodule
